// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared types and constants for the sequential divider
package seq_div_pkg;

    localparam int DEF_WIDTH = 16;

    // Wide enough for any practical WIDTH; users slice the low WIDTH bits.
    localparam logic [63:0] QUOT_ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division iteration
module div_restore_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] partial;

    // Shift the next dividend bit into the partial remainder, then try to subtract.
    // When the subtraction succeeds the true difference is below divisor, so the
    // low WIDTH bits of the modular difference are exact.
    always_comb begin
        partial = {rem_in, next_bit};
        q_bit   = (partial >= {1'b0, divisor});
        rem_out = q_bit ? (partial[WIDTH-1:0] - divisor) : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider_32by16.sv
// rtl/seq_divider_32by16.sv - iterative 2W/W restoring divider; optional SEQ_DIV_ZERO_SKIP_EN
module seq_divider_32by16
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    div_state_e       state_q, state_d;
    logic             init_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] divisor_q;
    logic             dbz_q;
    logic             ovf_q;

    logic             accept;
    logic             is_dbz;
    logic             is_ovf;
    logic             is_zero_div;
    logic             early_done;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    assign accept = in_valid && in_ready;
    assign is_dbz = (divisor == '0);
    assign is_ovf = (dividend[2*WIDTH-1:WIDTH] >= divisor);
`ifdef SEQ_DIV_ZERO_SKIP_EN
    assign is_zero_div = (dividend == '0);
`else
    assign is_zero_div = 1'b0;
`endif
    assign early_done = is_dbz || is_ovf || is_zero_div;

    // The shift register doubles as the quotient: dividend bits leave at the MSB
    // while quotient bits enter at the LSB, so after WIDTH steps it holds the result.
    assign quotient    = sreg_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (rem_q),
        .next_bit (sreg_q[WIDTH-1]),
        .divisor  (divisor_q),
        .rem_out  (rem_next),
        .q_bit    (q_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = early_done ? DONE : CALC;
            CALC: if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; in_ready stays low until the first clock after reset release.
    always_comb begin
        in_ready  = init_q && (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Marks that at least one clock has elapsed since reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
        end
    end

    // Operand capture, error results and per-cycle restoring iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            sreg_q    <= '0;
            divisor_q <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            divisor_q <= divisor;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            if (is_dbz) begin
                dbz_q  <= 1'b1;
                sreg_q <= QUOT_ALL_ONES[WIDTH-1:0];
                rem_q  <= dividend[WIDTH-1:0];
            end else if (is_ovf) begin
                ovf_q  <= 1'b1;
                sreg_q <= QUOT_ALL_ONES[WIDTH-1:0];
                rem_q  <= '0;
            end else if (is_zero_div) begin
                sreg_q <= '0;
                rem_q  <= '0;
            end else begin
                rem_q  <= dividend[2*WIDTH-1:WIDTH];
                sreg_q <= dividend[WIDTH-1:0];
                cnt_q  <= CNT_W'(WIDTH);
            end
        end else if (state_q == CALC) begin
            rem_q  <= rem_next;
            sreg_q <= {sreg_q[WIDTH-2:0], q_bit};
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_divider_32by16.sv
// tb/tb_seq_divider_32by16.sv - directed self-checking bench for seq_divider_32by16
module tb_seq_divider_32by16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int lat;

    seq_divider_32by16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operand pair and count clock edges until out_valid (bounded).
    task automatic run_op(input logic [31:0] dd, input logic [15:0] dv, output int n);
        @(negedge clk);
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n++;
        end while (!out_valid && n < 200);
        check("out_valid_reached", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                                input logic dbz, input logic ovf);
        check({tag, "_quotient"}, {16'd0, quotient}, {16'd0, q});
        check({tag, "_remainder"}, {16'd0, remainder}, {16'd0, r});
        check({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, dbz});
        check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, ovf});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        // Reset state
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_result("rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_before_clk", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rel_in_ready_after_clk", {31'd0, in_ready}, 32'd1);

        // 1: 12 / 4
        run_op(32'h0000_000C, 16'h0004, lat);
        check("t1_latency", lat, 32'd17);
        check_result("t1", 16'h0003, 16'h0000, 1'b0, 1'b0);
        consume();

        // 2: (0x1234*0x5678+5) / 0x5678
        run_op(32'h0626_0065, 16'h5678, lat);
        check("t2_latency", lat, 32'd17);
        check_result("t2", 16'h1234, 16'h0005, 1'b0, 1'b0);
        consume();

        // Largest non-overflowing quotient: 0xFFFEFFFF / 0xFFFF
        run_op(32'hFFFE_FFFF, 16'hFFFF, lat);
        check_result("max", 16'hFFFF, 16'hFFFE, 1'b0, 1'b0);
        consume();

        // 3: overflow, high half equal to divisor
        run_op(32'h0001_0000, 16'h0001, lat);
        check("t3_latency", lat, 32'd1);
        check_result("t3", 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        consume();

        // Overflow boundary with high half exactly equal to a larger divisor
        run_op(32'h1234_0000, 16'h1234, lat);
        check_result("ovf_eq", 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        consume();

        // 4: divide by zero
        run_op(32'h0000_ABCD, 16'h0000, lat);
        check("t4_latency", lat, 32'd1);
        check_result("t4", 16'hFFFF, 16'hABCD, 1'b1, 1'b0);
        consume();

        // 5: backpressure, 1000 / 7 = 142 r 6; flags from t4 must be cleared by this accept
        run_op(32'd1000, 16'd7, lat);
        check_result("t5", 16'h008E, 16'h0006, 1'b0, 1'b0);
        @(negedge clk);
        dividend = 32'd5;
        divisor  = 16'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t5_hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("t5_hold_quotient", {16'd0, quotient}, 32'h0000_008E);
            check("t5_hold_remainder", {16'd0, remainder}, 32'h0000_0006);
        end
        in_valid = 1'b0;
        consume();
        check("t5_after_out_valid", {31'd0, out_valid}, 32'd0);
        check("t5_after_in_ready", {31'd0, in_ready}, 32'd1);

        // 6: reset during the 8th CALC cycle
        @(negedge clk);
        dividend = 32'h0000_00E1;
        divisor  = 16'h000F;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_result("t6_rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_rel_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("t6_no_result", {31'd0, out_valid}, 32'd0);

        run_op(32'h0000_00E1, 16'h000F, lat);
        check("t6_latency", lat, 32'd17);
        check_result("t6", 16'h000F, 16'h0000, 1'b0, 1'b0);
        consume();

        // Zero dividend
        run_op(32'h0000_0000, 16'h000F, lat);
`ifdef SEQ_DIV_ZERO_SKIP_EN
        check("zero_latency", lat, 32'd1);
`else
        check("zero_latency", lat, 32'd17);
`endif
        check_result("zero", 16'h0000, 16'h0000, 1'b0, 1'b0);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
